// File: rtl/digit_pkg.sv
// Shared types and constants for the digit stabilizer.
// Contents: display state enum, the largest legal class code, the blank
// segment pattern, and the 0-9 seven-segment lookup table (gfedcba).
package digit_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } disp_state_t;

  localparam logic [3:0] CLASS_MAX = 4'd9;
  localparam logic [6:0] SEG_BLANK = 7'b000_0000;

  // Entry i holds the pattern for digit i; the first element of the
  // concatenation lands in the highest slot, so the list runs 9 down to 0.
  localparam logic [9:0][6:0] SEG_LUT = {
    7'b1101111,  // 9
    7'b1111111,  // 8
    7'b0000111,  // 7
    7'b1111101,  // 6
    7'b1101101,  // 5
    7'b1100110,  // 4
    7'b1001111,  // 3
    7'b1011011,  // 2
    7'b0000110,  // 1
    7'b0111111   // 0
  };

endpackage

// File: rtl/seg7_decode.sv
// Combinational 7-segment decoder, active-high {g,f,e,d,c,b,a}.
// Ports: digit[3:0] value to show, enable gates the display,
//        seg[6:0] pattern; all segments off for enable=0 or digit>9.
module seg7_decode
  import digit_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       enable,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (enable && (digit <= CLASS_MAX)) begin
      seg = SEG_LUT[digit];
    end
  end

endmodule

// File: rtl/digit_stabilizer.sv
// Debounces classifier output: a digit is displayed only after CONFIRM_N
// consecutive identical valid samples, held until timeout or clear.
// Ports: clk/rst (sync, active-high), class_in/class_valid sample stream,
//        clear; outputs digit, digit_valid, seg (7-seg), new_digit pulse.
module digit_stabilizer
  import digit_pkg::*;
#(
  parameter int CONFIRM_N      = 4,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] class_in,
  input  logic       class_valid,
  input  logic       clear,
  output logic [3:0] digit,
  output logic       digit_valid,
  output logic [6:0] seg,
  output logic       new_digit
);

  localparam int         TMR_W        = $clog2(TIMEOUT_CYCLES);
  localparam logic [3:0] CONFIRM_MAX  = 4'(CONFIRM_N);
  localparam logic [3:0] CONFIRM_LAST = 4'(CONFIRM_N - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  // Tracker state
  logic [3:0] cand_q, cand_d;
  logic [3:0] match_cnt_q, match_cnt_d;

  // Display state
  disp_state_t      state_q, state_d;
  logic [3:0]       digit_q, digit_d;
  logic             valid_q, valid_d;
  logic             new_q, new_d;
  logic [TMR_W-1:0] timer_q, timer_d;

  logic sample_ok;
  logic sample_match;
  logic confirm;

  assign sample_ok    = class_valid && (class_in <= CLASS_MAX);
  // A match needs a live run; a zero count means cand is stale.
  assign sample_match = sample_ok && (class_in == cand_q) && (match_cnt_q != 4'd0);
  // Covers both the sample that completes the run and saturated repeats.
  assign confirm      = sample_match && (match_cnt_q >= CONFIRM_LAST);

  // Tracker next state
  always_comb begin
    cand_d      = cand_q;
    match_cnt_d = match_cnt_q;
    if (clear) begin
      match_cnt_d = 4'd0;
    end else if (class_valid) begin
      if (!sample_ok) begin
        match_cnt_d = 4'd0;
      end else if (sample_match) begin
        if (match_cnt_q != CONFIRM_MAX) begin
          match_cnt_d = match_cnt_q + 4'd1;
        end
      end else begin
        cand_d      = class_in;
        match_cnt_d = 4'd1;
      end
    end
  end

  // Display FSM next state; clear outranks confirm, confirm outranks timeout.
  always_comb begin
    state_d = state_q;
    digit_d = digit_q;
    valid_d = valid_q;
    timer_d = timer_q;
    new_d   = 1'b0;
    if (clear) begin
      state_d = BLANK;
      valid_d = 1'b0;
      timer_d = '0;
    end else if (confirm) begin
      state_d = SHOW;
      valid_d = 1'b1;
      timer_d = '0;
      digit_d = cand_q;
      new_d   = (state_q == BLANK) || (cand_q != digit_q);
    end else if (state_q == SHOW) begin
      if (timer_q == TMR_LAST) begin
        state_d = BLANK;
        valid_d = 1'b0;
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cand_q      <= 4'd0;
      match_cnt_q <= 4'd0;
      state_q     <= BLANK;
      digit_q     <= 4'd0;
      valid_q     <= 1'b0;
      new_q       <= 1'b0;
      timer_q     <= '0;
    end else begin
      cand_q      <= cand_d;
      match_cnt_q <= match_cnt_d;
      state_q     <= state_d;
      digit_q     <= digit_d;
      valid_q     <= valid_d;
      new_q       <= new_d;
      timer_q     <= timer_d;
    end
  end

  assign digit       = digit_q;
  assign digit_valid = valid_q;
  assign new_digit   = new_q;

  seg7_decode u_seg7_decode (
    .digit  (digit_q),
    .enable (valid_q),
    .seg    (seg)
  );

endmodule

// File: tb/tb_digit_stabilizer.sv
module tb_digit_stabilizer;

  localparam int CN = 4;
  localparam int TO = 16;

  logic       clk;
  logic       rst;
  logic [3:0] class_in;
  logic       class_valid;
  logic       clear;
  logic [3:0] digit;
  logic       digit_valid;
  logic [6:0] seg;
  logic       new_digit;

  digit_stabilizer #(.CONFIRM_N(CN), .TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .class_in    (class_in),
    .class_valid (class_valid),
    .clear       (clear),
    .digit       (digit),
    .digit_valid (digit_valid),
    .seg         (seg),
    .new_digit   (new_digit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] d;
    logic       v;
    logic [6:0] s;
    logic       n;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   pulses = 0;

  // Reference model: run length of identical valid samples, age since confirm
  int         m_len;
  logic [3:0] m_cand;
  logic       m_shown;
  logic [3:0] m_digit;
  logic       m_new;
  int         m_age;

  function automatic logic [6:0] ref_seg(input logic [3:0] d, input logic v);
    logic [6:0] s;
    if (!v) return 7'b0000000;
    case (d)
      4'd0: s = 7'b0111111;
      4'd1: s = 7'b0000110;
      4'd2: s = 7'b1011011;
      4'd3: s = 7'b1001111;
      4'd4: s = 7'b1100110;
      4'd5: s = 7'b1101101;
      4'd6: s = 7'b1111101;
      4'd7: s = 7'b0000111;
      4'd8: s = 7'b1111111;
      4'd9: s = 7'b1101111;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_edge(input logic v, input logic [3:0] c, input logic cl, input logic r);
    logic conf;
    if (r) begin
      m_len = 0; m_cand = 4'd0; m_shown = 1'b0; m_digit = 4'd0; m_new = 1'b0; m_age = 0;
      return;
    end
    conf = 1'b0;
    if (v) begin
      if (c > 4'd9) m_len = 0;
      else if (m_len > 0 && c == m_cand) begin
        m_len++;
        conf = (m_len >= CN);
      end else begin
        m_cand = c;
        m_len  = 1;
      end
    end
    if (cl) begin
      m_len = 0; m_shown = 1'b0; m_new = 1'b0; m_age = 0;
    end else if (conf) begin
      m_new   = !m_shown || (m_digit != m_cand);
      m_shown = 1'b1;
      m_digit = m_cand;
      m_age   = 0;
    end else begin
      m_new = 1'b0;
      if (m_shown) begin
        m_age++;
        if (m_age >= TO) m_shown = 1'b0;
      end
    end
  endtask

  // One clock: drive, let the model predict, then compare after the edge.
  task automatic step(input logic v, input logic [3:0] c, input logic cl, input logic r);
    exp_t e;
    class_valid = v; class_in = c; clear = cl; rst = r;
    @(posedge clk);
    model_edge(v, c, cl, r);
    exp_q.push_back('{d: m_digit, v: m_shown, s: ref_seg(m_digit, m_shown), n: m_new});
    #1;
    e = exp_q.pop_front();
    chk("sb_digit", {4'd0, digit}, {4'd0, e.d});
    chk("sb_valid", {7'd0, digit_valid}, {7'd0, e.v});
    chk("sb_seg", {1'b0, seg}, {1'b0, e.s});
    chk("sb_new", {7'd0, new_digit}, {7'd0, e.n});
    if (new_digit === 1'b1) pulses++;
  endtask

  task automatic sample(input logic [3:0] c);
    step(1'b1, c, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_digit"}, {4'd0, digit}, 8'd0);
    chk({tag, "_valid"}, {7'd0, digit_valid}, 8'd0);
    chk({tag, "_seg"}, {1'b0, seg}, 8'd0);
    chk({tag, "_new"}, {7'd0, new_digit}, 8'd0);
  endtask

  initial begin
    rst = 1'b1; class_in = 4'd0; class_valid = 1'b0; clear = 1'b0;
    model_edge(1'b0, 4'd0, 1'b0, 1'b1);

    // Reset state
    step(1'b0, 4'd0, 1'b0, 1'b1);
    step(1'b0, 4'd0, 1'b0, 1'b1);
    chk_reset_outputs("reset");

    // Five 3s: shown after the fourth, fifth gives no pulse
    for (int i = 0; i < 3; i++) sample(4'd3);
    chk("t1_blank_before", {7'd0, digit_valid}, 8'd0);
    sample(4'd3);
    chk("t1_digit", {4'd0, digit}, 8'd3);
    chk("t1_valid", {7'd0, digit_valid}, 8'd1);
    chk("t1_seg", {1'b0, seg}, {1'b0, 7'b1001111});
    chk("t1_new", {7'd0, new_digit}, 8'd1);
    sample(4'd3);
    chk("t1_no_repulse", {7'd0, new_digit}, 8'd0);

    // 7,7,7,2,7,7,7,7: only the final 7 confirms
    pulses = 0;
    for (int i = 0; i < 3; i++) sample(4'd7);
    sample(4'd2);
    for (int i = 0; i < 3; i++) sample(4'd7);
    chk("t2_still_3", {4'd0, digit}, 8'd3);
    sample(4'd7);
    chk("t2_digit", {4'd0, digit}, 8'd7);
    chk("t2_seg", {1'b0, seg}, {1'b0, 7'b0000111});
    chk("t2_pulses", pulses[7:0], 8'd1);

    // Show 5, then timeout exactly 16 cycles after the confirm edge
    for (int i = 0; i < 4; i++) sample(4'd5);
    chk("t3_digit", {4'd0, digit}, 8'd5);
    idle(15);
    chk("t3_valid_at15", {7'd0, digit_valid}, 8'd1);
    idle(1);
    chk("t3_valid_at16", {7'd0, digit_valid}, 8'd0);
    chk("t3_seg_blank", {1'b0, seg}, 8'd0);
    chk("t3_digit_kept", {4'd0, digit}, 8'd5);

    // Re-confirm 5 at cycle 10 extends display to cycle 26
    step(1'b0, 4'd0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) sample(4'd5);
    chk("t3b_new", {7'd0, new_digit}, 8'd1);
    idle(9);
    sample(4'd5);
    chk("t3b_reconf_nopulse", {7'd0, new_digit}, 8'd0);
    idle(15);
    chk("t3b_valid_at25", {7'd0, digit_valid}, 8'd1);
    idle(1);
    chk("t3b_valid_at26", {7'd0, digit_valid}, 8'd0);

    // Show 4, then 9,9,12,9,9,9,9
    for (int i = 0; i < 4; i++) sample(4'd4);
    chk("t4_digit4", {4'd0, digit}, 8'd4);
    pulses = 0;
    sample(4'd9); sample(4'd9); sample(4'd12);
    for (int i = 0; i < 3; i++) sample(4'd9);
    chk("t4_still_4", {4'd0, digit}, 8'd4);
    chk("t4_no_pulse_yet", pulses[7:0], 8'd0);
    sample(4'd9);
    chk("t4_digit9", {4'd0, digit}, 8'd9);
    chk("t4_seg9", {1'b0, seg}, {1'b0, 7'b1101111});
    chk("t4_pulses", pulses[7:0], 8'd1);

    // Clear coinciding with the fourth 6
    for (int i = 0; i < 3; i++) sample(4'd6);
    step(1'b1, 4'd6, 1'b1, 1'b0);
    chk("t5_blank", {7'd0, digit_valid}, 8'd0);
    chk("t5_no_pulse", {7'd0, new_digit}, 8'd0);
    for (int i = 0; i < 3; i++) sample(4'd6);
    chk("t5_three_no_conf", {7'd0, digit_valid}, 8'd0);
    sample(4'd6);
    chk("t5_digit6", {4'd0, digit}, 8'd6);
    chk("t5_new", {7'd0, new_digit}, 8'd1);

    // Reset mid-run (count 3), then one more 8 must not confirm
    for (int i = 0; i < 3; i++) sample(4'd8);
    step(1'b1, 4'd8, 1'b0, 1'b1);
    chk_reset_outputs("t6_rst_midrun");
    sample(4'd8);
    chk("t6_no_conf", {7'd0, digit_valid}, 8'd0);

    // Reset while showing 8
    for (int i = 0; i < 4; i++) sample(4'd8);
    chk("t6_show8", {4'd0, digit}, 8'd8);
    step(1'b1, 4'd8, 1'b0, 1'b1);
    chk_reset_outputs("t6_rst_show");
    sample(4'd8);
    chk("t6_no_conf2", {7'd0, digit_valid}, 8'd0);
    chk("t6_no_pulse2", {7'd0, new_digit}, 8'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
